// File: rtl/demo_audio_synth_if.sv
// demo_audio_synth_if: sync-timing inputs, song controls and audio outputs of the line-rate synth.
interface demo_audio_synth_if;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        line_strobe;
  logic        frame_strobe;
  logic        play;
  logic [2:0]  voice_mask;
  logic        audio;
  logic        playing;
  logic [12:0] song_pos;
  modport master (
    output hpos, vpos, line_strobe, frame_strobe, play, voice_mask,
    input  audio, playing, song_pos
  );
  modport slave (
    input  hpos, vpos, line_strobe, frame_strobe, play, voice_mask,
    output audio, playing, song_pos
  );
endinterface

// File: rtl/demo_audio_synth.sv
// demo_audio_synth: three-voice (kick, noise snare, ROM lead) 1-bit audio driven by VGA sync timing.
module demo_audio_synth #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          NOISE_DIV  = 3,
  parameter int          KICK_LINES = 255,
  parameter int          SNARE_X0   = 32,
  parameter int          LEAD_X0    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  demo_audio_synth_if.slave bus
);
  typedef enum logic {STOPPED, PLAYING} state_t;
  localparam logic [8:0] ROM [8] = '{9'd151, 9'd26, 9'd40, 9'd60, 9'd90, 9'd143, 9'd23, 9'd35};
  state_t      state_q;
  logic        playing_q, audio_q, noise_q, note_q;
  logic [12:0] song_pos_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  ndiv_q;
  logic [8:0]  note_cnt_q, freq;
  logic [4:0]  env_a, env_b;
  logic [10:0] h, v;
  logic        beat, kick, snare, lead, ndiv_wrap, note_wrap;
  always_comb begin
    h         = {1'b0, bus.hpos};
    v         = {1'b0, bus.vpos};
    env_a     = 5'd31 - song_pos_q[4:0];
    env_b     = 5'd31 - {song_pos_q[3:0], 1'b0};
    beat      = song_pos_q[5:4] == 2'b10;
    freq      = ROM[song_pos_q[7:5]];
    kick      = (v < 11'(KICK_LINES)) && (h < {6'd0, env_a});
    snare     = noise_q && beat && (h >= 11'(SNARE_X0)) && (h < 11'(SNARE_X0) + {6'd0, env_b});
    lead      = note_q && (h >= 11'(LEAD_X0)) && (h < 11'(LEAD_X0) + {6'd0, env_b});
    ndiv_wrap = ndiv_q == 8'(NOISE_DIV - 1);
    note_wrap = note_cnt_q > freq;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= STOPPED;
      playing_q  <= 1'b0;
      audio_q    <= 1'b0;
      song_pos_q <= '0;
      lfsr_q     <= LFSR_SEED;
      noise_q    <= 1'b0;
      ndiv_q     <= '0;
      note_cnt_q <= '0;
      note_q     <= 1'b0;
    end else begin
      audio_q <= (state_q == PLAYING) && |(bus.voice_mask & {lead, snare, kick});
      if (bus.line_strobe) begin
        ndiv_q <= ndiv_wrap ? '0 : ndiv_q + 8'd1;
        if (ndiv_wrap) begin
          lfsr_q  <= lfsr_d;
          noise_q <= noise_q ^ lfsr_q[0];
        end
        if (state_q == PLAYING) begin
          note_cnt_q <= note_wrap ? '0 : note_cnt_q + 9'd1;
          note_q     <= note_wrap ? ~note_q : note_q;
        end
      end
      // Song start/stop only takes effect on frame boundaries
      if (bus.frame_strobe) begin
        case (state_q)
          STOPPED: if (bus.play) begin
            state_q    <= PLAYING;
            playing_q  <= 1'b1;
            song_pos_q <= '0;
          end
          PLAYING: if (!bus.play) begin
            state_q   <= STOPPED;
            playing_q <= 1'b0;
          end else begin
            song_pos_q <= song_pos_q + 13'd1;
          end
          default: state_q <= STOPPED;
        endcase
      end
    end
  end
  assign bus.audio    = audio_q;
  assign bus.playing  = playing_q;
  assign bus.song_pos = song_pos_q;
endmodule
